if_fetch: RTL

- Instruction-fetch stage. Owns the PC and assembles each 32-bit instruction from a byte-wide memory port shared with the MEM stage through an external arbiter.
- Presents {pc_o, inst_o} with a valid flag to the IF/ID register, which feeds the decode stage.
- Honours the decode load-use stall and the EX-stage branch/jump redirect.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants for the instruction-fetch stage.
//   - state encodings for the fetch FSM (plain localparams, legacy-compatible)
//   - memory byte width, instruction/address widths, bytes per instruction
package if_fetch_pkg;

  localparam int INST_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int MEM_BYTE_W     = 8;
  localparam int BYTES_PER_INST = 4;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] IF_FETCH = 1'b0;  // issuing / collecting bytes
  localparam logic [STATE_W-1:0] IF_READY = 1'b1;  // instruction presented

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
//   Owns the PC and assembles each 32-bit little-endian instruction from a
//   byte-wide memory port shared with the MEM stage through an arbiter.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall_i           downstream cannot accept the presented instruction
//   br_flag_i         redirect request from EX (branch taken, JAL, JALR)
//   br_target_i       redirect PC
//   mem_grant_i       arbiter grants the byte port to IF this cycle
//   mem_data_i        read byte for the address granted in the previous cycle
//   mem_req_o         IF requests the byte port
//   mem_addr_o        requested byte address
//   pc_o, inst_o      presented PC and instruction
//   inst_valid_o      pc_o/inst_o hold a complete instruction
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  br_flag_i,
  input  logic [ADDR_W-1:0]     br_target_i,
  input  logic                  mem_grant_i,
  input  logic [MEM_BYTE_W-1:0] mem_data_i,
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic [INST_W-1:0]     inst_o,
  output logic                  inst_valid_o
);

  logic [STATE_W-1:0] state;
  logic [ADDR_W-1:0]  pc_r;
  logic [2:0]         issue_idx;  // next byte to request, 0..4
  logic               pend;       // a granted byte returns this cycle
  logic [1:0]         pend_idx;   // which byte is returning
  // Only bytes 0..2 need buffering: byte 3 goes straight into inst_o.
  logic [3*MEM_BYTE_W-1:0] lo_bytes;

  logic grant;
  logic last_byte;

  // Request the port while bytes remain to be issued. A redirect cycle makes
  // no request, so no byte from the abandoned PC is ever granted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    mem_req_o  = 1'b0;
    mem_addr_o = ZERO_WORD;
    if (!rst && !br_flag_i && state == IF_FETCH &&
        issue_idx < 3'(BYTES_PER_INST)) begin
      mem_req_o  = 1'b1;
      mem_addr_o = pc_r + {29'd0, issue_idx};
    end
  end

  assign grant     = mem_req_o & mem_grant_i;
  assign last_byte = pend && (pend_idx == 2'd3);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IF_FETCH;
      pc_r         <= RESET_PC;
      issue_idx    <= '0;
      pend         <= 1'b0;
      pend_idx     <= '0;
      lo_bytes     <= '0;
      pc_o         <= ZERO_WORD;
      inst_o       <= ZERO_WORD;
      inst_valid_o <= 1'b0;
    end else if (br_flag_i) begin
      // Redirect beats stall and capture; any in-flight byte is dropped.
      state        <= IF_FETCH;
      pc_r         <= br_target_i;
      issue_idx    <= '0;
      pend         <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state)
        IF_FETCH: begin
          // Issue and capture overlap: a new grant can coincide with the
          // return of the previous byte.
          pend <= grant;
          if (grant) begin
            issue_idx <= issue_idx + 3'd1;
            pend_idx  <= issue_idx[1:0];
          end
          if (pend && !last_byte) begin
            lo_bytes[{pend_idx, 3'b000} +: MEM_BYTE_W] <= mem_data_i;
          end
          if (last_byte) begin
            state        <= IF_READY;
            inst_o       <= {mem_data_i, lo_bytes};
            pc_o         <= pc_r;
            inst_valid_o <= 1'b1;
          end
        end
        IF_READY: begin
          // Stalled: hold everything. Otherwise the word is consumed now.
          if (!stall_i) begin
            state        <= IF_FETCH;
            pc_r         <= pc_r + 32'(BYTES_PER_INST);
            issue_idx    <= '0;
            inst_valid_o <= 1'b0;
          end
        end
        default: state <= IF_FETCH;
      endcase
    end
  end

endmodule
